fetch_request_unit: RTL and testbench

- Owns the architectural PC register and sequences memory requests for the multicycle-latency CPU: instruction fetch, then an optional data access, then commit.
- Consumes the next-PC value from the PC-update logic and drives the PC back to it.
- Sits between the datapath/control decode and the memory controller's iREN/dREN/dWEN/ihit/dhit interface.
- Produces a one-cycle commit strobe that qualifies register-file writes.

---
 rtl/cpu_types_pkg.sv | 16 +
 rtl/fetch_request_unit_if.sv | 32 +++
 rtl/fetch_perf_counter.sv | 38 +++
 rtl/fetch_request_unit.sv | 92 +++++++++
 tb/tb_fetch_request_unit.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch sequencer states and PC alignment helper.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  function automatic word_t alignPc(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_request_unit_if.sv
// Bundle of decode, PC-update and memory-controller signals around the fetch unit.
interface fetch_request_unit_if;
  import cpu_types_pkg::*;

  word_t next_pc;
  word_t imemload;
  logic  ihit;
  logic  dhit;
  logic  dmem_rd;
  logic  dmem_wr;
  logic  halt;
  word_t pc;
  word_t instr;
  logic  iREN;
  logic  dREN;
  logic  dWEN;
  logic  commit;
  logic  halted;
  word_t cycle_cnt;
  word_t instr_cnt;

  modport master (
    input  next_pc, imemload, ihit, dhit, dmem_rd, dmem_wr, halt,
    output pc, instr, iREN, dREN, dWEN, commit, halted, cycle_cnt, instr_cnt
  );

  modport slave (
    output next_pc, imemload, ihit, dhit, dmem_rd, dmem_wr, halt,
    input  pc, instr, iREN, dREN, dWEN, commit, halted, cycle_cnt, instr_cnt
  );

endinterface

// File: rtl/fetch_perf_counter.sv
// Saturating cycle/instruction counter pair; only built when FETCH_PERF_CNT_EN is defined.
`ifdef FETCH_PERF_CNT_EN
module fetch_perf_counter
  import cpu_types_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  cycle_en_i,
  input  logic  instr_en_i,
  output word_t cycle_cnt_o,
  output word_t instr_cnt_o
);

  word_t cycle_q, cycle_d;
  word_t instr_q, instr_d;

  always_comb begin
    cycle_d = cycle_q;
    instr_d = instr_q;
    if (cycle_en_i && (cycle_q != '1)) cycle_d = cycle_q + 32'd1;
    if (instr_en_i && (instr_q != '1)) instr_d = instr_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      instr_q <= instr_d;
    end
  end

  assign cycle_cnt_o = cycle_q;
  assign instr_cnt_o = instr_q;

endmodule
`endif

// File: rtl/fetch_request_unit.sv
// PC owner and fetch/data/commit request sequencer for the multicycle CPU.
// Define FETCH_PERF_CNT_EN to build the cycle/instruction performance counters.
module fetch_request_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input logic                  CLK,
  input logic                  RST,
  fetch_request_unit_if.master bus
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        instr_q, instr_d;
  logic         commit, iREN, dREN, dWEN;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      FETCH: begin
        if (bus.ihit) begin
          instr_d = bus.imemload;
          if (bus.halt)                         state_d = HALTED;
          else if (bus.dmem_rd || bus.dmem_wr)  state_d = DATA;
        end
      end
      DATA: begin
        if (bus.dhit) state_d = FETCH;
      end
      default: state_d = state_q;
    endcase
    if (commit) pc_d = alignPc(bus.next_pc);
  end

  // Requests follow the state directly so an async reset drops them at once.
  always_comb begin
    iREN   = 1'b0;
    dREN   = 1'b0;
    dWEN   = 1'b0;
    commit = 1'b0;
    case (state_q)
      FETCH: begin
        iREN   = ~RST;
        commit = bus.ihit & ~bus.halt & ~(bus.dmem_rd | bus.dmem_wr);
      end
      DATA: begin
        dWEN   = bus.dmem_wr;
        dREN   = bus.dmem_rd & ~bus.dmem_wr;
        commit = bus.dhit;
      end
      default: commit = 1'b0;
    endcase
  end

  assign bus.pc     = pc_q;
  assign bus.instr  = (state_q == FETCH) ? bus.imemload : instr_q;
  assign bus.iREN   = iREN;
  assign bus.dREN   = dREN;
  assign bus.dWEN   = dWEN;
  assign bus.commit = commit;
  assign bus.halted = (state_q == HALTED);

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_counter u_perf (
    .clk         (CLK),
    .rst         (RST),
    .cycle_en_i  (state_q != HALTED),
    .instr_en_i  (commit),
    .cycle_cnt_o (bus.cycle_cnt),
    .instr_cnt_o (bus.instr_cnt)
  );
`else
  assign bus.cycle_cnt = '0;
  assign bus.instr_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_request_unit.sv
// Directed scoreboard bench for fetch_request_unit (PC_INIT = 0x100).
module tb_fetch_request_unit;
  import cpu_types_pkg::*;

  localparam word_t PC0   = 32'h0000_0100;
  localparam word_t ADDW  = 32'h00A0_0033;
  localparam word_t LWW   = 32'h0001_2083;
  localparam word_t SWW   = 32'h0020_A023;
  localparam word_t HALTW = 32'hFFFF_FFFF;
  localparam word_t JUNK  = 32'hDEAD_BEEF;

  typedef struct {
    string       tag;
    logic [4:0]  ctl;
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk;
  logic rst;
  int   testsRun;
  int   failCount;
  exp_t sb[$];

  fetch_request_unit_if bus ();

  fetch_request_unit #(.PC_INIT(PC0)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic ih, dh, rd, wr, hl, input word_t npc);
    bus.ihit    = ih;
    bus.dhit    = dh;
    bus.dmem_rd = rd;
    bus.dmem_wr = wr;
    bus.halt    = hl;
    bus.next_pc = npc;
  endtask

  // Pops the oldest expectation and compares it with the DUT outputs now.
  task automatic checkOutput();
    exp_t       e;
    logic [4:0] obsCtl;
    if (sb.size() == 0) begin
      testsRun++;
      failCount++;
      $display("[TB] FAIL scoreboard_empty observed=0 required=1");
      return;
    end
    e = sb.pop_front();
    obsCtl = {bus.iREN, bus.dREN, bus.dWEN, bus.commit, bus.halted};
    testsRun++;
    assert (obsCtl === e.ctl) else begin
      failCount++;
      $error("[TB] FAIL %s ctl{iREN,dREN,dWEN,commit,halted} observed=%b expected=%b", e.tag, obsCtl, e.ctl);
    end
    testsRun++;
    assert (bus.pc === e.pc) else begin
      failCount++;
      $error("[TB] FAIL %s pc observed=%h expected=%h", e.tag, bus.pc, e.pc);
    end
    testsRun++;
    assert (bus.instr === e.instr) else begin
      failCount++;
      $error("[TB] FAIL %s instr observed=%h expected=%h", e.tag, bus.instr, e.instr);
    end
  endtask

  task automatic step(input string tag, input logic ih, dh, rd, wr, hl, input word_t npc,
                      input logic [4:0] ctl, input word_t expPc, expInstr);
    applyStimulus(ih, dh, rd, wr, hl, npc);
    sb.push_back('{tag, ctl, expPc, expInstr});
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  initial begin
    word_t perfPc;
    word_t expCyc;
    word_t expIns;
    testsRun  = 0;
    failCount = 0;
    rst = 1'b1;
    bus.imemload = ADDW;
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    step("reset",     0, 0, 0, 0, 0, 32'h0, 5'b10000, PC0, ADDW);

    for (int i = 0; i < 3; i++)
      step("add_wait", 0, 0, 0, 0, 0, 32'h104, 5'b10000, PC0, ADDW);
    step("add_ihit",  1, 0, 0, 0, 0, 32'h104, 5'b10010, PC0, ADDW);
    step("add_post",  0, 0, 0, 0, 0, 32'h0,   5'b10000, 32'h104, ADDW);

    bus.imemload = LWW;
    step("ld_ihit",   1, 0, 1, 0, 0, 32'h200, 5'b10000, 32'h104, LWW);
    bus.imemload = JUNK;
    step("ld_wait0",  1, 0, 1, 0, 0, 32'h200, 5'b01000, 32'h104, LWW);
    step("ld_wait1",  0, 0, 1, 0, 0, 32'h200, 5'b01000, 32'h104, LWW);
    step("ld_dhit",   0, 1, 1, 0, 0, 32'h200, 5'b01010, 32'h104, LWW);
    step("ld_post",   0, 0, 0, 0, 0, 32'h0,   5'b10000, 32'h200, JUNK);
    step("dhit_fetch",0, 1, 0, 0, 0, 32'h300, 5'b10000, 32'h200, JUNK);

    bus.imemload = SWW;
    step("st_ihit",   1, 0, 1, 1, 0, 32'h204, 5'b10000, 32'h200, SWW);
    bus.imemload = JUNK;
    step("st_ihit_ign",1, 0, 1, 1, 0, 32'h204, 5'b00100, 32'h200, SWW);
    step("st_dhit",   0, 1, 1, 1, 0, 32'h204, 5'b00110, 32'h200, SWW);
    step("st_post",   0, 0, 0, 0, 0, 32'h0,   5'b10000, 32'h204, JUNK);

    bus.imemload = ADDW;
    step("np7_ihit",  1, 0, 0, 0, 0, 32'h7,   5'b10010, 32'h204, ADDW);
    step("np7_post",  0, 0, 0, 0, 0, 32'h0,   5'b10000, 32'h4, ADDW);

    bus.imemload = LWW;
    step("ld2_ihit",  1, 0, 1, 0, 0, 32'h8,   5'b10000, 32'h4, LWW);
    bus.imemload = JUNK;
    step("ld2_data",  0, 0, 1, 0, 0, 32'h8,   5'b01000, 32'h4, LWW);
    #2 rst = 1'b1;
    #1;
    sb.push_back('{"async_rst", 5'b00000, PC0, JUNK});
    checkOutput();
    @(posedge clk);
    #1 rst = 1'b0;
    step("post_rst",  0, 0, 0, 0, 0, 32'h0,   5'b10000, PC0, JUNK);

    bus.imemload = HALTW;
    step("halt_ihit", 1, 0, 1, 0, 1, 32'h300, 5'b10000, PC0, HALTW);
    bus.imemload = JUNK;
    step("halted",    0, 0, 1, 0, 1, 32'h300, 5'b00001, PC0, HALTW);
    step("halt_pulse",1, 1, 1, 1, 0, 32'h300, 5'b00001, PC0, HALTW);
    step("halted2",   0, 0, 0, 0, 0, 32'h0,   5'b00001, PC0, HALTW);
    rst = 1'b1;
    #1;
    sb.push_back('{"halt_rst", 5'b00000, PC0, JUNK});
    checkOutput();
    @(posedge clk);
    #1 rst = 1'b0;

    bus.imemload = ADDW;
    perfPc = PC0;
    for (int i = 0; i < 5; i++) begin
      step("perf_wait", 0, 0, 0, 0, 0, perfPc + 32'd4, 5'b10000, perfPc, ADDW);
      step("perf_ihit", 1, 0, 0, 0, 0, perfPc + 32'd4, 5'b10010, perfPc, ADDW);
      perfPc = perfPc + 32'd4;
    end
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    expCyc = 32'd10;
    expIns = 32'd5;
`else
    expCyc = 32'd0;
    expIns = 32'd0;
`endif
    @(negedge clk);
    testsRun++;
    assert (bus.cycle_cnt === expCyc) else begin
      failCount++;
      $error("[TB] FAIL cycle_cnt observed=%0d expected=%0d", bus.cycle_cnt, expCyc);
    end
    testsRun++;
    assert (bus.instr_cnt === expIns) else begin
      failCount++;
      $error("[TB] FAIL instr_cnt observed=%0d expected=%0d", bus.instr_cnt, expIns);
    end
    sb.push_back('{"perf_pc", 5'b10000, 32'h114, ADDW});
    checkOutput();

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
